// File: rtl/dvi_tmds_encode.sv
// DVI 1.0 TMDS encoder: expands 4-bit RGB to 8 bits and emits three 10-bit symbols per pixel.
// Two-stage pipeline; defining TMDS_OUTPUT_REG_EN adds a third output register stage.
module dvi_tmds_encode (
  input  logic       clk,
  input  logic       reset_i,
  input  logic [3:0] red_i,
  input  logic [3:0] green_i,
  input  logic [3:0] blue_i,
  input  logic       hsync_i,
  input  logic       vsync_i,
  input  logic       dv_de_i,
  output logic [9:0] tmds_red_o,
  output logic [9:0] tmds_green_o,
  output logic [9:0] tmds_blue_o,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       dv_de_o
);

  localparam logic [9:0] TokCtl00 = 10'h354;
  localparam logic [9:0] TokCtl01 = 10'h0ab;
  localparam logic [9:0] TokCtl10 = 10'h154;
  localparam logic [9:0] TokCtl11 = 10'h2ab;

  function automatic logic [3:0] count_ones(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  function automatic logic [8:0] tmds_qm(input logic [7:0] d);
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] qm;
    n1       = count_ones(d);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    qm       = '0;
    qm[0]    = d[0];
    for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = ~use_xnor;
    return qm;
  endfunction

  // Returns {symbol[9:0], next disparity[4:0]}; all disparity math wraps in 5-bit two's complement.
  function automatic logic [14:0] tmds_balance(input logic [8:0] qm, input logic [4:0] cnt);
    logic [3:0] n1;
    logic [4:0] disp;
    logic [9:0] sym;
    logic [4:0] cnt_n;
    n1   = count_ones(qm[7:0]);
    disp = {n1, 1'b0} - 5'd8;
    if ((cnt == 5'd0) || (n1 == 4'd4)) begin
      sym   = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      cnt_n = qm[8] ? (cnt + disp) : (cnt - disp);
    end else if ((!cnt[4] && (n1 > 4'd4)) || (cnt[4] && (n1 < 4'd4))) begin
      sym   = {1'b1, qm[8], ~qm[7:0]};
      cnt_n = cnt + {3'b000, qm[8], 1'b0} - disp;
    end else begin
      sym   = {1'b0, qm[8], qm[7:0]};
      cnt_n = cnt - {3'b000, ~qm[8], 1'b0} + disp;
    end
    return {sym, cnt_n};
  endfunction

  function automatic logic [9:0] ctl_token(input logic [1:0] c);
    logic [9:0] tok;
    unique case (c)
      2'b00:   tok = TokCtl00;
      2'b01:   tok = TokCtl01;
      2'b10:   tok = TokCtl10;
      default: tok = TokCtl11;
    endcase
    return tok;
  endfunction

  // Channel index: 0 = blue, 1 = green, 2 = red.
  logic [2:0][7:0] pix;
  logic [2:0][8:0] qm_d, qm_q;
  logic            hs1_q, vs1_q, de1_q;

  assign pix[0] = {blue_i, blue_i};
  assign pix[1] = {green_i, green_i};
  assign pix[2] = {red_i, red_i};

  always_comb begin
    qm_d = '0;
    for (int ch = 0; ch < 3; ch++) qm_d[ch] = tmds_qm(pix[ch]);
  end

  logic [2:0][9:0] sym_d, sym_q;
  logic [2:0][4:0] cnt_d, cnt_q;
  logic            hs2_q, vs2_q, de2_q;

  always_comb begin
    sym_d = sym_q;
    cnt_d = cnt_q;
    for (int ch = 0; ch < 3; ch++) begin
      if (de1_q) begin
        {sym_d[ch], cnt_d[ch]} = tmds_balance(qm_q[ch], cnt_q[ch]);
      end else begin
        // Only blue carries sync during blanking; disparity restarts from zero.
        sym_d[ch] = (ch == 0) ? ctl_token({vs1_q, hs1_q}) : TokCtl00;
        cnt_d[ch] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      qm_q  <= '0;
      hs1_q <= 1'b0;
      vs1_q <= 1'b0;
      de1_q <= 1'b0;
      sym_q <= {3{TokCtl00}};
      cnt_q <= '0;
      hs2_q <= 1'b0;
      vs2_q <= 1'b0;
      de2_q <= 1'b0;
    end else begin
      qm_q  <= qm_d;
      hs1_q <= hsync_i;
      vs1_q <= vsync_i;
      de1_q <= dv_de_i;
      sym_q <= sym_d;
      cnt_q <= cnt_d;
      hs2_q <= hs1_q;
      vs2_q <= vs1_q;
      de2_q <= de1_q;
    end
  end

`ifdef TMDS_OUTPUT_REG_EN
  logic [2:0][9:0] sym3_q;
  logic            hs3_q, vs3_q, de3_q;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      sym3_q <= {3{TokCtl00}};
      hs3_q  <= 1'b0;
      vs3_q  <= 1'b0;
      de3_q  <= 1'b0;
    end else begin
      sym3_q <= sym_q;
      hs3_q  <= hs2_q;
      vs3_q  <= vs2_q;
      de3_q  <= de2_q;
    end
  end

  assign tmds_blue_o  = sym3_q[0];
  assign tmds_green_o = sym3_q[1];
  assign tmds_red_o   = sym3_q[2];
  assign hsync_o      = hs3_q;
  assign vsync_o      = vs3_q;
  assign dv_de_o      = de3_q;
`else
  assign tmds_blue_o  = sym_q[0];
  assign tmds_green_o = sym_q[1];
  assign tmds_red_o   = sym_q[2];
  assign hsync_o      = hs2_q;
  assign vsync_o      = vs2_q;
  assign dv_de_o      = de2_q;
`endif

endmodule

// File: tb/tb_dvi_tmds_encode.sv
// Bench for dvi_tmds_encode: directed TMDS sequences plus random pixels against a reference model.
module tb_dvi_tmds_encode;

`ifdef TMDS_OUTPUT_REG_EN
  localparam int Lat = 3;
`else
  localparam int Lat = 2;
`endif

  typedef struct packed {
    logic [9:0] r;
    logic [9:0] g;
    logic [9:0] b;
    logic       hs;
    logic       vs;
    logic       de;
  } out_t;

  logic       clk = 1'b0;
  logic       reset_i;
  logic [3:0] red_i, green_i, blue_i;
  logic       hsync_i, vsync_i, dv_de_i;
  logic [9:0] tmds_red_o, tmds_green_o, tmds_blue_o;
  logic       hsync_o, vsync_o, dv_de_o;

  int checks = 0;
  int errors = 0;

  int   mcnt[3];
  out_t pipe[$];
  logic [9:0] obs_r[$], obs_g[$], obs_b[$];
  logic       obs_de[$];

  dvi_tmds_encode dut (
    .clk          (clk),
    .reset_i      (reset_i),
    .red_i        (red_i),
    .green_i      (green_i),
    .blue_i       (blue_i),
    .hsync_i      (hsync_i),
    .vsync_i      (vsync_i),
    .dv_de_i      (dv_de_i),
    .tmds_red_o   (tmds_red_o),
    .tmds_green_o (tmds_green_o),
    .tmds_blue_o  (tmds_blue_o),
    .hsync_o      (hsync_o),
    .vsync_o      (vsync_o),
    .dv_de_o      (dv_de_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] token(input logic [1:0] c);
    case (c)
      2'b00:   return 10'h354;
      2'b01:   return 10'h0ab;
      2'b10:   return 10'h154;
      default: return 10'h2ab;
    endcase
  endfunction

  // Reference: stage-1 bit i is the parity of D[i:0], flipped on odd bits in XNOR mode;
  // symbol bit 9 is simply "data bits were inverted".
  function automatic logic [9:0] enc(input int ch, input logic [3:0] c);
    logic [7:0] dv, qm;
    int         n1, nq, diff, q8, dpart;
    bit         use_xnor, inv;
    dv       = {4'b0000, c} * 8'd17;
    n1       = $countones(dv);
    use_xnor = (n1 > 4) || (n1 == 4 && dv[0] == 1'b0);
    for (int i = 0; i < 8; i++) begin
      dpart = int'(dv) & ((2 << i) - 1);
      qm[i] = (($countones(dpart) % 2) == 1) ^ (use_xnor && (i % 2 == 1));
    end
    q8   = use_xnor ? 0 : 1;
    nq   = $countones(qm);
    diff = 2 * nq - 8;
    if (mcnt[ch] == 0 || diff == 0) begin
      inv = (q8 == 0);
      mcnt[ch] += (q8 == 1) ? diff : -diff;
    end else if ((mcnt[ch] > 0 && diff > 0) || (mcnt[ch] < 0 && diff < 0)) begin
      inv = 1'b1;
      mcnt[ch] += 2 * q8 - diff;
    end else begin
      inv = 1'b0;
      mcnt[ch] += diff - 2 * (1 - q8);
    end
    return {inv, (q8 == 1), inv ? ~qm : qm};
  endfunction

  function automatic out_t model(input logic [3:0] r, g, b, input logic hs, vs, de);
    out_t e;
    e.hs = hs;
    e.vs = vs;
    e.de = de;
    if (de) begin
      e.b = enc(0, b);
      e.g = enc(1, g);
      e.r = enc(2, r);
    end else begin
      mcnt = '{0, 0, 0};
      e.b  = token({vs, hs});
      e.g  = 10'h354;
      e.r  = 10'h354;
    end
    return e;
  endfunction

  function automatic out_t rst_out();
    out_t e;
    e = '{r: 10'h354, g: 10'h354, b: 10'h354, hs: 1'b0, vs: 1'b0, de: 1'b0};
    return e;
  endfunction

  task automatic step(input logic [3:0] r, g, b, input logic hs, vs, de, input logic rst);
    out_t e;
    red_i   = r;
    green_i = g;
    blue_i  = b;
    hsync_i = hs;
    vsync_i = vs;
    dv_de_i = de;
    reset_i = rst;
    if (rst) begin
      pipe.delete();
      for (int i = 0; i < Lat; i++) pipe.push_back(rst_out());
      mcnt = '{0, 0, 0};
    end else begin
      e = model(r, g, b, hs, vs, de);
      void'(pipe.pop_front());
      pipe.push_back(e);
    end
    @(posedge clk);
    #1;
    check("blue", tmds_blue_o, pipe[0].b);
    check("green", tmds_green_o, pipe[0].g);
    check("red", tmds_red_o, pipe[0].r);
    check("hs_vs_de", {7'd0, hsync_o, vsync_o, dv_de_o}, {7'd0, pipe[0].hs, pipe[0].vs, pipe[0].de});
    obs_r.push_back(tmds_red_o);
    obs_g.push_back(tmds_green_o);
    obs_b.push_back(tmds_blue_o);
    obs_de.push_back(dv_de_o);
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) step(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Symbols produced for the input of step k (global index), taken from the observation log.
  task automatic check_log(input string tag, input int k, input logic [9:0] er, eg, eb);
    check({tag, "_r"}, obs_r[k+Lat-1], er);
    check({tag, "_g"}, obs_g[k+Lat-1], eg);
    check({tag, "_b"}, obs_b[k+Lat-1], eb);
  endtask

  initial begin
    int k0;
    logic [9:0] blk[4];
    logic [9:0] tok[4];
    blk = '{10'h100, 10'h3ff, 10'h100, 10'h3ff};
    tok = '{10'h354, 10'h0ab, 10'h154, 10'h2ab};
    for (int i = 0; i < Lat; i++) pipe.push_back(rst_out());

    // Reset held for 3 cycles with arbitrary inputs.
    for (int i = 0; i < 3; i++) begin
      step(4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b1);
      check("rst_blue", tmds_blue_o, 10'h354);
      check("rst_de", {9'd0, dv_de_o}, 10'd0);
    end
    step(4'h5, 4'ha, 4'h3, 1'b1, 1'b1, 1'b1, 1'b0);
    check("post_rst_blue", tmds_blue_o, 10'h354);
    check("post_rst_de", {9'd0, dv_de_o}, 10'd0);
    blank(Lat);

    // Control tokens for {vsync, hsync} = 00, 01, 10, 11.
    k0 = obs_b.size();
    for (int i = 0; i < 4; i++) step(4'h0, 4'h0, 4'h0, 1'(i % 2), 1'(i / 2), 1'b0, 1'b0);
    blank(Lat);
    for (int i = 0; i < 4; i++) check_log("token", k0 + i, 10'h354, 10'h354, tok[i]);

    // Black line after blanking.
    k0 = obs_b.size();
    for (int i = 0; i < 4; i++) step(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    blank(Lat);
    for (int i = 0; i < 4; i++) check_log("black", k0 + i, blk[i], blk[i], blk[i]);

    // White line after blanking.
    k0 = obs_b.size();
    for (int i = 0; i < 2; i++) step(4'hf, 4'hf, 4'hf, 1'b0, 1'b0, 1'b1, 1'b0);
    blank(Lat);
    check_log("white0", k0, 10'h200, 10'h200, 10'h200);
    check_log("white1", k0 + 1, 10'h0ff, 10'h0ff, 10'h0ff);

    // Three black pixels, one blanking cycle, then black restarts from zero disparity.
    k0 = obs_b.size();
    for (int i = 0; i < 3; i++) step(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    blank(1);
    step(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    blank(Lat);
    check_log("clr_pre", k0 + 2, 10'h100, 10'h100, 10'h100);
    check_log("clr_post", k0 + 4, 10'h100, 10'h100, 10'h100);
    check("clr_de", {9'd0, obs_de[k0+4+Lat-1]}, 10'd1);

    // Random pixels with blanking bursts and occasional mid-line reset.
    for (int i = 0; i < 600; i++) begin
      step(4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 7) != 0), ($urandom_range(0, 63) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
